// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational one.
module muldiv_unit #(
  parameter int XLEN         = 32,
  parameter int ALUCTR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
  input  logic [XLEN-1:0]         op_a,
  input  logic [XLEN-1:0]         op_b,
  output logic                    busy,
  output logic                    done,
  output logic [XLEN-1:0]         result
);

  localparam int CntW = $clog2(XLEN);

  localparam logic [ALUCTR_WIDTH-1:0] OpMul    = ALUCTR_WIDTH'(10);
  localparam logic [ALUCTR_WIDTH-1:0] OpMulh   = ALUCTR_WIDTH'(11);
  localparam logic [ALUCTR_WIDTH-1:0] OpMulhsu = ALUCTR_WIDTH'(12);
  localparam logic [ALUCTR_WIDTH-1:0] OpMulhu  = ALUCTR_WIDTH'(13);
  localparam logic [ALUCTR_WIDTH-1:0] OpDiv    = ALUCTR_WIDTH'(14);
  localparam logic [ALUCTR_WIDTH-1:0] OpDivu   = ALUCTR_WIDTH'(15);
  localparam logic [ALUCTR_WIDTH-1:0] OpRem    = ALUCTR_WIDTH'(16);
  localparam logic [ALUCTR_WIDTH-1:0] OpRemu   = ALUCTR_WIDTH'(17);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e                  state_q;
  logic [ALUCTR_WIDTH-1:0] ctrl_q;
  logic [2*XLEN-1:0]       acc_q;
  logic [2*XLEN-1:0]       mcand_q;
  logic [XLEN-1:0]         opB_q;
  logic                    neg_q;
  logic [CntW-1:0]         iter_q;
  logic                    busy_q;
  logic                    done_q;
  logic [XLEN-1:0]         result_q;

  logic              inMul, inDiv, inValid;
  logic              aSigned, bSigned, negIn;
  logic [XLEN-1:0]   magA, magB;
  logic              specialIn;
  logic [XLEN-1:0]   specialRes;
  logic [2*XLEN-1:0] fastProd;

  logic              curMul;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN-1:0]   quoSigned, remSigned;
  logic [XLEN-1:0]   result_d;

  // Decode the incoming request and prepare magnitudes plus the early-exit cases.
  always_comb begin
    inMul      = (alu_ctrl == OpMul) || (alu_ctrl == OpMulh) ||
                 (alu_ctrl == OpMulhsu) || (alu_ctrl == OpMulhu);
    inDiv      = (alu_ctrl == OpDiv) || (alu_ctrl == OpDivu) ||
                 (alu_ctrl == OpRem) || (alu_ctrl == OpRemu);
    inValid    = inMul || inDiv;
    aSigned    = (alu_ctrl == OpMulh) || (alu_ctrl == OpMulhsu) ||
                 (alu_ctrl == OpDiv) || (alu_ctrl == OpRem);
    bSigned    = (alu_ctrl == OpMulh) || (alu_ctrl == OpDiv) || (alu_ctrl == OpRem);
    magA       = (aSigned && op_a[XLEN-1]) ? -op_a : op_a;
    magB       = (bSigned && op_b[XLEN-1]) ? -op_b : op_b;
    // A remainder follows the dividend sign only; everything else uses the sign product.
    negIn      = (alu_ctrl == OpRem) ? op_a[XLEN-1]
               : ((aSigned && op_a[XLEN-1]) ^ (bSigned && op_b[XLEN-1]));
    fastProd   = '0;
    specialIn  = 1'b0;
    specialRes = '0;
    if (inDiv && (op_b == '0)) begin
      specialIn  = 1'b1;
      specialRes = ((alu_ctrl == OpDiv) || (alu_ctrl == OpDivu)) ? '1 : op_a;
    end else if (((alu_ctrl == OpDiv) || (alu_ctrl == OpRem)) &&
                 (op_a == MinNeg) && (op_b == '1)) begin
      specialIn  = 1'b1;
      specialRes = (alu_ctrl == OpDiv) ? MinNeg : '0;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (inMul) begin
      fastProd   = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
      fastProd   = negIn ? -fastProd : fastProd;
      specialIn  = 1'b1;
      specialRes = (alu_ctrl == OpMul) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration step: conditional add for multiply, trial subtract for divide.
  always_comb begin
    curMul = (ctrl_q == OpMul) || (ctrl_q == OpMulh) ||
             (ctrl_q == OpMulhsu) || (ctrl_q == OpMulhu);
    acc_d  = acc_q;
    trial  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opB_q};
    if (curMul) begin
      if (opB_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
    end else if (!trial[XLEN]) begin
      acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end

    prodSigned = neg_q ? -acc_d : acc_d;
    quoSigned  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    remSigned  = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    case (ctrl_q)
      OpMul:                    result_d = prodSigned[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: result_d = prodSigned[2*XLEN-1:XLEN];
      OpDiv, OpDivu:            result_d = quoSigned;
      default:                  result_d = remSigned;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opB_q    <= '0;
      neg_q    <= 1'b0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && inValid) begin
            ctrl_q  <= alu_ctrl;
            neg_q   <= negIn;
            mcand_q <= {{XLEN{1'b0}}, magA};
            opB_q   <= magB;
            acc_q   <= inMul ? '0 : {{XLEN{1'b0}}, magA};
            iter_q  <= '0;
            if (specialIn) begin
              result_q <= specialRes;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          opB_q   <= curMul ? (opB_q >> 1) : opB_q;
          iter_q  <= iter_q + 1'b1;
          if (iter_q == CntW'(XLEN-1)) begin
            result_q <= result_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors are queued at issue and checked by a monitor on each done pulse.
// Expected multiply latency follows MULDIV_FAST_MUL_EN when the bench is built with it.
module tb_muldiv_unit;

  localparam int XLEN         = 32;
  localparam int ALUCTR_WIDTH = 5;

  localparam logic [4:0] OpMul    = 5'b01010;
  localparam logic [4:0] OpMulh   = 5'b01011;
  localparam logic [4:0] OpMulhsu = 5'b01100;
  localparam logic [4:0] OpMulhu  = 5'b01101;
  localparam logic [4:0] OpDiv    = 5'b01110;
  localparam logic [4:0] OpDivu   = 5'b01111;
  localparam logic [4:0] OpRem    = 5'b10000;
  localparam logic [4:0] OpRemu   = 5'b10001;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat  = 1;
  localparam int MulBusy = 0;
`else
  localparam int MulLat  = 33;
  localparam int MulBusy = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(
    .XLEN        (XLEN),
    .ALUCTR_WIDTH(ALUCTR_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_ctrl(alu_ctrl),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          busyCycles;
    int          acceptCycle;
  } exp_t;

  exp_t sb[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   cycleCnt    = 0;
  int   busyCnt     = 0;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse pops one expectation; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_result"}, result, e.res);
          checkOutput({e.name, "_latency"}, 32'(cycleCnt - e.acceptCycle + 1), 32'(e.lat));
          checkOutput({e.name, "_busy_cycles"}, 32'(busyCnt), 32'(e.busyCycles));
        end
        busyCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [4:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int lat,
                               input int busyCycles);
    exp_t e;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.name        = name;
    e.res         = expRes;
    e.lat         = lat;
    e.busyCycles  = busyCycles;
    e.acceptCycle = cycleCnt;
    sb.push_back(e);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic runOp(input string name, input logic [4:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int lat,
                       input int busyCycles);
    applyStimulus(name, ctrl, a, b, expRes, lat, busyCycles);
    waitDrain();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    alu_ctrl = '0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("mul",    OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat, MulBusy);
    runOp("mulhu",  OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, MulBusy);
    runOp("mulhsu", OpMulhsu, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MulLat, MulBusy);
    runOp("mulh",   OpMulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MulLat, MulBusy);
    runOp("div",    OpDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 32);
    runOp("rem",    OpRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 32);
    runOp("divu",   OpDivu,   32'd100,        32'd7,         32'd14,        33, 32);
    runOp("remu",   OpRemu,   32'd100,        32'd7,         32'd2,         33, 32);
    runOp("divu_by0", OpDivu, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
    runOp("remu_by0", OpRemu, 32'd5,          32'd0,         32'd5,         1, 0);
    runOp("div_ovf",  OpDiv,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    runOp("rem_ovf",  OpRem,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);

    // A start during CALC must be dropped, leaving the in-flight result intact.
    applyStimulus("divu_ignore", OpDivu, 32'd100, 32'd7, 32'd14, 33, 32);
    repeat (10) @(negedge clk);
    alu_ctrl = OpMulhu;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'hFFFF_FFFF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (40) @(negedge clk);
    checkOutput("ignore_idle_busy", 32'(busy), 32'd0);

    // An unrecognised control code never leaves IDLE.
    alu_ctrl = 5'b00101;
    op_a     = 32'd3;
    op_b     = 32'd4;
    start    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("badcode_busy", 32'(busy), 32'd0);
      checkOutput("badcode_done", 32'(done), 32'd0);
    end
    start = 1'b0;

    // Reset mid-CALC clears outputs immediately and drops the pending operation.
    alu_ctrl = OpDivu;
    op_a     = 32'd1000;
    op_b     = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_done", 32'(done), 32'd0);
    checkOutput("async_reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    runOp("divu_after_reset", OpDivu, 32'd9, 32'd3, 32'd3, 33, 32);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
